// File: rtl/audio_clip_player.sv
// Clip playback engine: streams one sample-ROM clip at a fixed sample rate and
// turns each 8-bit sample into a mono PWM bit, pulsing playback_complete at the end.
module audio_clip_player #(
  parameter int ADDR_W     = 14,
  parameter int SAMPLE_DIV = 12500,
  parameter logic [ADDR_W-1:0] CLIP1_BASE = ADDR_W'(0),
  parameter logic [ADDR_W-1:0] CLIP1_LEN  = ADDR_W'(2000),
  parameter logic [ADDR_W-1:0] CLIP2_BASE = ADDR_W'(2000),
  parameter logic [ADDR_W-1:0] CLIP2_LEN  = ADDR_W'(6000),
  parameter logic [ADDR_W-1:0] CLIP3_BASE = ADDR_W'(8000),
  parameter logic [ADDR_W-1:0] CLIP3_LEN  = ADDR_W'(8000)
) (
  input  logic              Clk,
  input  logic              reset_rtl_0,
  input  logic              en,
  input  logic [1:0]        audio_select,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              leftsound,
  output logic              rightsound,
  output logic              playback_complete
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  // ROM data for the current address is on the bus during the div==1 cycle
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic              start_s;
  logic              run_s;
  logic              wrap_s;
  logic              finish_s;
  logic [ADDR_W-1:0] sel_base_s;
  logic [ADDR_W-1:0] sel_len_s;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W-1:0] len_r;
  logic [ADDR_W-1:0] idx_r;
  logic [ADDR_W-1:0] rom_addr_r;
  logic [DIV_W-1:0]  div_r;
  logic [7:0]        pwm_cnt_r;
  logic [7:0]        sample_r;
  logic              pwm_r;
  logic              complete_r;

  assign rom_addr          = rom_addr_r;
  assign leftsound         = pwm_r;
  assign rightsound        = pwm_r;
  assign playback_complete = complete_r;

  // Clip table lookup for the requested select value
  always_comb begin
    sel_base_s = {ADDR_W{1'b0}};
    sel_len_s  = {ADDR_W{1'b0}};
    case (audio_select)
      2'b01: begin
        sel_base_s = CLIP1_BASE;
        sel_len_s  = CLIP1_LEN;
      end
      2'b10: begin
        sel_base_s = CLIP2_BASE;
        sel_len_s  = CLIP2_LEN;
      end
      2'b11: begin
        sel_base_s = CLIP3_BASE;
        sel_len_s  = CLIP3_LEN;
      end
      default: begin
        sel_base_s = {ADDR_W{1'b0}};
        sel_len_s  = {ADDR_W{1'b0}};
      end
    endcase
  end

  // State register
  always_ff @(posedge Clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; an abort (en low) takes priority over end of clip
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    run_s        = 1'b0;
    wrap_s       = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (en && (audio_select != 2'b00)) begin
          start_s = 1'b1;
          if (sel_len_s == {ADDR_W{1'b0}}) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_PLAY;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (!en) begin
          state_next_s = ST_IDLE;
        end else if (div_r == DIV_LAST) begin
          wrap_s = 1'b1;
          if (idx_r == (len_r - ADDR_W'(1))) begin
            finish_s     = 1'b1;
            state_next_s = ST_DONE;
          end else begin
            run_s        = 1'b1;
            state_next_s = ST_PLAY;
          end
        end else begin
          run_s        = 1'b1;
          state_next_s = ST_PLAY;
        end
      end
      ST_DONE: begin
        if (!en) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Datapath: clip addressing, sample timing, sample capture and PWM
  always_ff @(posedge Clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      base_r     <= {ADDR_W{1'b0}};
      len_r      <= {ADDR_W{1'b0}};
      idx_r      <= {ADDR_W{1'b0}};
      rom_addr_r <= {ADDR_W{1'b0}};
      div_r      <= {DIV_W{1'b0}};
      pwm_cnt_r  <= 8'd0;
      sample_r   <= 8'd0;
      pwm_r      <= 1'b0;
      complete_r <= 1'b0;
    end else if (start_s) begin
      base_r     <= sel_base_s;
      len_r      <= sel_len_s;
      idx_r      <= {ADDR_W{1'b0}};
      rom_addr_r <= sel_base_s;
      div_r      <= {DIV_W{1'b0}};
      pwm_cnt_r  <= 8'd0;
      sample_r   <= 8'd0;
      pwm_r      <= 1'b0;
      complete_r <= (sel_len_s == {ADDR_W{1'b0}});
    end else if (run_s) begin
      pwm_cnt_r  <= pwm_cnt_r + 8'd1;
      pwm_r      <= (pwm_cnt_r < sample_r);
      complete_r <= 1'b0;
      if (div_r == DIV_LOAD) begin
        sample_r <= rom_data;
      end
      if (wrap_s) begin
        div_r      <= {DIV_W{1'b0}};
        idx_r      <= idx_r + ADDR_W'(1);
        rom_addr_r <= base_r + idx_r + ADDR_W'(1);
      end else begin
        div_r <= div_r + DIV_W'(1);
      end
    end else begin
      pwm_r      <= 1'b0;
      complete_r <= finish_s;
    end
  end

endmodule

// File: tb/tb_audio_clip_player.sv
// Scoreboard bench for audio_clip_player: per-clip expected traces are computed
// from the playback timing rules and checked cycle by cycle by a monitor.
module tb_audio_clip_player;

  localparam int ADDR_W = 14;
  localparam int D      = 512;
  localparam int AMOD   = 16384;
  localparam int B1 = 0;     localparam int L1 = 3;
  localparam int B2 = 16382; localparam int L2 = 3;
  localparam int B3 = 500;   localparam int L3 = 0;

  logic              Clk = 1'b0;
  logic              reset_rtl_0;
  logic              en;
  logic [1:0]        audio_select;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data = 8'd0;
  logic              leftsound;
  logic              rightsound;
  logic              playback_complete;

  logic [7:0] rom_mem [0:AMOD-1];

  typedef struct {
    int         k;
    logic       snd;
    logic       cmp;
    logic       chk_addr;
    logic [13:0] addr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total  = 0;
  int   passed = 0;

  audio_clip_player #(
    .ADDR_W(ADDR_W), .SAMPLE_DIV(D),
    .CLIP1_BASE(14'(B1)), .CLIP1_LEN(14'(L1)),
    .CLIP2_BASE(14'(B2)), .CLIP2_LEN(14'(L2)),
    .CLIP3_BASE(14'(B3)), .CLIP3_LEN(14'(L3))
  ) dut (
    .Clk(Clk), .reset_rtl_0(reset_rtl_0), .en(en), .audio_select(audio_select),
    .rom_addr(rom_addr), .rom_data(rom_data), .leftsound(leftsound),
    .rightsound(rightsound), .playback_complete(playback_complete)
  );

  always #5 Clk = ~Clk;

  // synchronous sample ROM
  always @(posedge Clk) rom_data <= rom_mem[rom_addr];

  task automatic check(input string name, input int k, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", name, k, act, exp);
  endtask

  // monitor: one expected entry per clock cycle while a trace is pending
  always @(negedge Clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("leftsound", mon_e.k, int'(leftsound), int'(mon_e.snd));
      check("rightsound", mon_e.k, int'(rightsound), int'(mon_e.snd));
      check("playback_complete", mon_e.k, int'(playback_complete), int'(mon_e.cmp));
      if (mon_e.chk_addr) check("rom_addr", mon_e.k, int'(rom_addr), int'(mon_e.addr));
    end
  end

  function automatic int clip_base(input logic [1:0] sel);
    case (sel)
      2'b01:   return B1;
      2'b10:   return B2;
      2'b11:   return B3;
      default: return 0;
    endcase
  endfunction

  function automatic int clip_len(input logic [1:0] sel);
    case (sel)
      2'b01:   return L1;
      2'b10:   return L2;
      2'b11:   return L3;
      default: return 0;
    endcase
  endfunction

  // PWM level driven in the cycle after clip cycle j
  function automatic logic pwm_level(input int base, input int j);
    int n, p, s;
    n = j / D;
    p = j % D;
    if (p >= 2) s = int'(rom_mem[(base + n) % AMOD]);
    else if (n == 0) s = 0;
    else s = int'(rom_mem[(base + n - 1) % AMOD]);
    return (j % 256) < s;
  endfunction

  task automatic push(input int k, input logic snd, input logic cmp, input logic chk, input int addr);
    exp_t e;
    e.k = k; e.snd = snd; e.cmp = cmp; e.chk_addr = chk; e.addr = 14'(addr);
    exp_q.push_back(e);
  endtask

  task automatic build_trace(input int base, input int len, input int abort_at,
                             input int rst_at, input int extra);
    int play, stop;
    play = len * D;
    if (abort_at >= 0) stop = abort_at;
    else if (rst_at >= 0) stop = rst_at;
    else stop = play + 1 + extra;
    for (int k = 0; k < stop; k++) begin
      if (k < play)
        push(k, (k == 0) ? 1'b0 : pwm_level(base, k - 1), 1'b0, 1'b1, (base + k / D) % AMOD);
      else
        push(k, 1'b0, (k == play), (len == 0), base);
    end
    for (int k = stop; k < stop + extra; k++) begin
      if (abort_at >= 0) push(k, 1'b0, 1'b0, 1'b0, 0);
      else if (rst_at >= 0) push(k, 1'b0, 1'b0, 1'b1, 0);
    end
  endtask

  task automatic run_clip(input logic [1:0] sel, input int abort_at, input int chg_at,
                          input int rst_at, input int extra);
    int c;
    audio_select = sel;
    en = 1'b1;
    @(posedge Clk); #1;
    build_trace(clip_base(sel), clip_len(sel), abort_at, rst_at, extra);
    c = 0;
    while (exp_q.size() != 0 && c < 20000) begin
      if (c == abort_at - 1) en = 1'b0;
      if (c == chg_at) audio_select = ~sel;
      if (c == rst_at) begin
        reset_rtl_0 = 1'b0;
        en = 1'b0;
      end
      @(posedge Clk); #1;
      c++;
    end
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL trace_timeout cycle %0d: got %0d pending expected 0", c, exp_q.size());
      exp_q.delete();
    end
    en = 1'b0;
    reset_rtl_0 = 1'b1;
    @(posedge Clk); #1;
  endtask

  initial begin
    for (int a = 0; a < AMOD; a++) rom_mem[a] = 8'($urandom_range(0, 255));
    reset_rtl_0 = 1'b0;
    en = 1'b1;
    audio_select = 2'b01;
    for (int k = 0; k < 5; k++) push(k, 1'b0, 1'b0, 1'b1, 0);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge Clk);
    #1;
    reset_rtl_0 = 1'b1;
    en = 1'b0;
    @(posedge Clk); #1;

    // nominal: constant 64 gives 64 high cycles per 256
    for (int a = 0; a < 3; a++) rom_mem[B1 + a] = 8'd64;
    run_clip(2'b01, -1, -1, -1, 4);

    // random sample data, including an address wrap past 2^ADDR_W
    for (int a = 0; a < 3; a++) rom_mem[B1 + a] = 8'($urandom_range(1, 254));
    run_clip(2'b01, -1, -1, -1, 3);
    run_clip(2'b10, -1, -1, -1, 3);

    // abort then restart from base
    run_clip(2'b01, 700, -1, -1, 5);
    run_clip(2'b01, -1, -1, -1, 2);

    // select change mid-clip, hold in DONE, then one low cycle restarts
    run_clip(2'b10, -1, 300, -1, 20);
    run_clip(2'b01, -1, -1, -1, 2);

    // zero-length clip
    run_clip(2'b11, -1, -1, -1, 8);

    // duty limits
    for (int a = 0; a < 3; a++) rom_mem[B1 + a] = 8'd0;
    run_clip(2'b01, -1, -1, -1, 2);
    for (int a = 0; a < 3; a++) rom_mem[B1 + a] = 8'd255;
    run_clip(2'b01, -1, -1, -1, 2);

    // asynchronous reset mid-clip while output would be high
    rom_mem[16383] = 8'd255;
    run_clip(2'b10, -1, -1, 1000, 6);
    run_clip(2'b01, -1, -1, -1, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
